// File: rtl/mem_ctr.sv
// rtl/mem_ctr.sv - line-oriented backing memory with fixed-latency read/write responses on a shared C2/D2 bus
// The cache drives the bus in IDLE; the memory owns it from the cycle after a command until release.
module mem_ctr #(
  parameter int MEM_SIZE        = 524288,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int ADDR2_BUS_SIZE  = 15,
  parameter int DATA2_BUS_SIZE  = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int MEM_LATENCY     = 100,
  parameter int SEED            = 225526
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR2_BUS_SIZE-1:0] A2,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2
);

  localparam int BPB     = DATA2_BUS_SIZE / 8;
  localparam int BEATS   = CACHE_LINE_SIZE / BPB;
  localparam int MEM_AW  = $clog2(MEM_SIZE);
  localparam int LINE_SH = $clog2(CACHE_LINE_SIZE);
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int CNT_W   = $clog2(MEM_LATENCY + BEATS + 1);

  localparam logic [CTR2_BUS_SIZE-1:0] C_NOP   = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C_RESP  = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C_READ  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C_WRITE = CTR2_BUS_SIZE'(3);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT, S_RESP} state_t;
  typedef logic [7:0] image_t [MEM_SIZE];

  // Power-up image: one $random draw per byte, ascending address, from a single seed.
  function automatic image_t seeded_image();
    image_t img;
    int     seed;
    seed = SEED;
    for (int i = 0; i < MEM_SIZE; i++) img[i] = 8'($random(seed) >> 16);
    return img;
  endfunction

  image_t mem_q = seeded_image();

  state_t                      state_q, state_d;
  logic [ADDR2_BUS_SIZE-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [BEAT_W-1:0]           idx_q, idx_d;
  logic                        is_wr_q, is_wr_d;
  logic [DATA2_BUS_SIZE-1:0]   beat_q [BEATS];
  logic [DATA2_BUS_SIZE-1:0]   beat_d [BEATS];
  logic                        commit;
  logic [MEM_AW-1:0]           base;
  logic [DATA2_BUS_SIZE-1:0]   rdata;

  assign base = {addr_q, {LINE_SH{1'b0}}};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      is_wr_q <= 1'b0;
      beat_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      is_wr_q <= is_wr_d;
      beat_q  <= beat_d;
    end
  end

  // cnt_q holds (edges since the command edge + 1), so it equals MEM_LATENCY on the response edge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    beat_d  = beat_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (C2 == C_READ) begin
          addr_d  = A2;
          cnt_d   = CNT_W'(1);
          idx_d   = '0;
          is_wr_d = 1'b0;
          state_d = S_WAIT;
        end else if (C2 == C_WRITE) begin
          addr_d    = A2;
          cnt_d     = CNT_W'(1);
          beat_d[0] = D2;
          idx_d     = BEAT_W'(1);
          is_wr_d   = 1'b1;
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        beat_d[idx_q] = D2;
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q + BEAT_W'(1);
        if (idx_q == BEAT_W'(BEATS - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MEM_LATENCY)) begin
          state_d = S_RESP;
          idx_d   = '0;
          commit  = is_wr_q;
        end
      end
      default: begin
        idx_d = idx_q + BEAT_W'(1);
        if (is_wr_q || idx_q == BEAT_W'(BEATS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
    endcase
  end

  // Writes land only on the response edge, so a reset anywhere earlier leaves storage untouched.
  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int k = 0; k < BEATS; k++)
        for (int j = 0; j < BPB; j++)
          mem_q[base + MEM_AW'(k * BPB + j)] <= beat_q[k][8*j +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < BPB; j++)
      rdata[8*j +: 8] = mem_q[base + MEM_AW'(idx_q) * MEM_AW'(BPB) + MEM_AW'(j)];
  end

  assign C2 = (state_q == S_IDLE) ? 'z : ((state_q == S_RESP) ? C_RESP : C_NOP);
  assign D2 = (state_q == S_RESP && !is_wr_q) ? rdata : 'z;

endmodule
